// File: rtl/bc_preg_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bc_preg_arbiter_if                                               |
// | Brief   : Request bundle from execution pipes and the broadcast bus out.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface bc_preg_arbiter_if #(
    parameter int N_REQ         = 4,
    parameter int I_BL_MARC_REG = 6,
    parameter int I_BL_ARC_REG  = 5,
    parameter int D_BL_MARC_REG = 32
);
    logic [N_REQ-1:0]               req_valid;
    logic [N_REQ-1:0]               req_ready;
    logic [N_REQ*I_BL_MARC_REG-1:0] req_i_preg;
    logic [N_REQ*I_BL_ARC_REG-1:0]  req_i_areg;
    logic [N_REQ*D_BL_MARC_REG-1:0] req_d_preg;
    logic [I_BL_MARC_REG-1:0]       i_preg_rb1;
    logic [I_BL_ARC_REG-1:0]        i_areg_rb1;
    logic [D_BL_MARC_REG-1:0]       d_preg_rb1;

    // Pipe / listener side
    modport master (
        output req_valid, req_i_preg, req_i_areg, req_d_preg,
        input  req_ready, i_preg_rb1, i_areg_rb1, d_preg_rb1
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_i_preg, req_i_areg, req_d_preg,
        output req_ready, i_preg_rb1, i_areg_rb1, d_preg_rb1
    );
endinterface
`default_nettype wire

// File: rtl/bc_preg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bc_preg_arbiter                                                  |
// | Brief   : Round-robin arbiter sharing the preg broadcast bus among pipes.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bc_preg_arbiter #(
    parameter int N_REQ         = 4,
    parameter int I_BL_MARC_REG = 6,
    parameter int I_BL_ARC_REG  = 5,
    parameter int D_BL_MARC_REG = 32,
    parameter int W_CNT         = 16
) (
    input  logic                       c_clock,
    input  logic                       c_reset,
    input  logic                       c_enable,
    input  logic                       c_pause,
    input  logic                       c_flush,
    bc_preg_arbiter_if.slave           bus,
    output logic [$clog2(N_REQ)-1:0]   s_grant_id,
    output logic                       s_err_zero,
    output logic [W_CNT-1:0]           s_bcast_cnt
);
    localparam int              W_ID    = $clog2(N_REQ);
    localparam logic [W_ID:0]   C_N_REQ = (W_ID+1)'(N_REQ);
    localparam logic [W_ID-1:0] C_LAST  = W_ID'(N_REQ-1);

    logic [I_BL_MARC_REG-1:0] w_preg [N_REQ];
    logic [I_BL_ARC_REG-1:0]  w_areg [N_REQ];
    logic [D_BL_MARC_REG-1:0] w_data [N_REQ];
    logic [N_REQ-1:0]         w_elig;
    logic [N_REQ-1:0]         w_zero;

    logic [I_BL_MARC_REG-1:0] preg_q, preg_d;
    logic [I_BL_ARC_REG-1:0]  areg_q, areg_d;
    logic [D_BL_MARC_REG-1:0] data_q, data_d;
    logic [W_ID-1:0]          gid_q,  gid_d;
    logic [W_ID-1:0]          rr_q,   rr_d;
    logic                     err_q,  err_d;
    logic [W_CNT-1:0]         cnt_q,  cnt_d;

    logic                     w_found;
    logic [W_ID-1:0]          w_win;
    logic [W_ID:0]            w_sum;
    logic [W_ID-1:0]          w_cand;
    logic                     w_accept_ok;
    logic                     w_xfer;
    logic [N_REQ-1:0]         w_ready;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_preg[g] = bus.req_i_preg[g*I_BL_MARC_REG +: I_BL_MARC_REG];
        assign w_areg[g] = bus.req_i_areg[g*I_BL_ARC_REG  +: I_BL_ARC_REG];
        assign w_data[g] = bus.req_d_preg[g*D_BL_MARC_REG +: D_BL_MARC_REG];
        assign w_elig[g] = bus.req_valid[g] && (w_preg[g] != '0);
        assign w_zero[g] = bus.req_valid[g] && (w_preg[g] == '0);
    end

    // First eligible pipe scanning upward from rr_q, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, rr_q} + (W_ID+1)'(k);
            if (w_sum >= C_N_REQ) begin
                w_sum = w_sum - C_N_REQ;
            end
            w_cand = w_sum[W_ID-1:0];
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_accept_ok = c_reset & c_enable & ~c_pause & ~c_flush;
    assign w_xfer      = w_found & w_accept_ok;

    // Zero-preg requests are swallowed unconditionally so they cannot wedge a pipe.
    always_comb begin
        w_ready = w_zero & {N_REQ{c_reset}};
        if (w_xfer) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        preg_d = preg_q;
        areg_d = areg_q;
        data_d = data_q;
        gid_d  = gid_q;
        rr_d   = rr_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (|w_zero);
        if (c_flush) begin
            preg_d = '0;
        end else if (!c_pause) begin
            if (w_xfer) begin
                preg_d = w_preg[w_win];
                areg_d = w_areg[w_win];
                data_d = w_data[w_win];
                gid_d  = w_win;
                rr_d   = (w_win == C_LAST) ? '0 : w_win + 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                preg_d = '0;
            end
        end
    end

    always_ff @(posedge c_clock or negedge c_reset) begin
        if (!c_reset) begin
            preg_q <= '0;
            areg_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
            rr_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            preg_q <= preg_d;
            areg_q <= areg_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            rr_q   <= rr_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.i_preg_rb1 = preg_q;
    assign bus.i_areg_rb1 = areg_q;
    assign bus.d_preg_rb1 = data_q;
    assign s_grant_id     = gid_q;
    assign s_err_zero     = err_q;
    assign s_bcast_cnt    = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_bc_preg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bc_preg_arbiter                                               |
// | Brief   : Self-checking bench: vector table, scoreboard and corner cases.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bc_preg_arbiter;
    localparam int N  = 4;
    localparam int IW = 6;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WC = 4;
    localparam int CMAX = (1 << WC) - 1;

    typedef struct packed {
        logic [IW-1:0] preg;
        logic [AW-1:0] areg;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } bc_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  zero;
        logic          en;
        logic          pause;
        logic          flush;
        logic [N-1:0]  exp_ready;
        logic [IW-1:0] exp_preg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic pause = 1'b0;
    logic flush = 1'b0;
    logic [1:0]    gid;
    logic          err;
    logic [WC-1:0] cnt;

    logic [N-1:0]  p_valid;
    logic [IW-1:0] p_preg [N];
    logic [AW-1:0] p_areg [N];
    logic [DW-1:0] p_data [N];

    int   n_chk = 0;
    int   n_fail = 0;
    int   m_rr, m_cnt;
    bit   m_err;
    bc_t  m_out;
    bc_t  sbq [$];
    vec_t vecs [11];

    bc_preg_arbiter_if #(.N_REQ(N), .I_BL_MARC_REG(IW), .I_BL_ARC_REG(AW),
                         .D_BL_MARC_REG(DW)) bus ();

    bc_preg_arbiter #(.N_REQ(N), .I_BL_MARC_REG(IW), .I_BL_ARC_REG(AW),
                      .D_BL_MARC_REG(DW), .W_CNT(WC)) dut (
        .c_clock     (clk),
        .c_reset     (rst_n),
        .c_enable    (en),
        .c_pause     (pause),
        .c_flush     (flush),
        .bus         (bus),
        .s_grant_id  (gid),
        .s_err_zero  (err),
        .s_bcast_cnt (cnt)
    );

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.req_i_preg[g*IW +: IW] = p_preg[g];
        assign bus.req_i_areg[g*AW +: AW] = p_areg[g];
        assign bus.req_d_preg[g*DW +: DW] = p_data[g];
    end
    assign bus.req_valid = p_valid;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (p_valid[idx] && p_preg[idx] != '0) return idx;
        end
        return -1;
    endfunction

    task automatic set_std(input logic [N-1:0] valid, input logic [N-1:0] zero);
        p_valid = valid;
        for (int i = 0; i < N; i++) begin
            p_preg[i] = zero[i] ? '0 : IW'(8 + i);
            p_areg[i] = AW'(1 + i);
            p_data[i] = 32'hA000_0000 + DW'(i);
        end
    endtask

    // One clock: check ready against the model, push any accepted result,
    // then after the edge pop/compare the broadcast and the status outputs.
    task automatic step(input string tag);
        int           w;
        logic [N-1:0] er;
        bit           ok, zany;
        bc_t          e;
        #1;
        w    = model_winner();
        ok   = rst_n && en && !pause && !flush;
        er   = '0;
        zany = 0;
        for (int i = 0; i < N; i++) begin
            if (p_valid[i] && p_preg[i] == '0) begin
                er[i] = rst_n;
                zany  = 1;
            end
        end
        if (w >= 0 && ok) begin
            er[w]  = 1'b1;
            e.preg = p_preg[w];
            e.areg = p_areg[w];
            e.data = p_data[w];
            e.id   = 2'(w);
            sbq.push_back(e);
        end
        chk({tag, " ready"}, 64'(bus.req_ready), 64'(er));
        @(posedge clk);
        #1;
        if (zany) m_err = 1;
        if (sbq.size() > 0) begin
            m_out = sbq.pop_front();
            m_rr  = (w + 1) % N;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (!pause || flush) begin
            m_out.preg = '0;
        end
        chk({tag, " preg"}, 64'(bus.i_preg_rb1), 64'(m_out.preg));
        chk({tag, " areg"}, 64'(bus.i_areg_rb1), 64'(m_out.areg));
        chk({tag, " data"}, 64'(bus.d_preg_rb1), 64'(m_out.data));
        chk({tag, " gid"},  64'(gid), 64'(m_out.id));
        chk({tag, " cnt"},  64'(cnt), 64'(m_cnt));
        chk({tag, " err"},  64'(err), 64'(m_err));
    endtask

    task automatic apply_reset(input bit now);
        if (!now) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst preg",  64'(bus.i_preg_rb1), 64'd0);
        chk("rst areg",  64'(bus.i_areg_rb1), 64'd0);
        chk("rst data",  64'(bus.d_preg_rb1), 64'd0);
        chk("rst gid",   64'(gid), 64'd0);
        chk("rst err",   64'(err), 64'd0);
        chk("rst cnt",   64'(cnt), 64'd0);
        chk("rst ready", 64'(bus.req_ready), 64'd0);
        m_rr  = 0;
        m_cnt = 0;
        m_err = 0;
        m_out = '0;
        sbq.delete();
        p_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        valid    zero     en    pause flush  ready    preg
        vecs[0]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 6'd11};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 6'd8};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 6'd9};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100, 6'd10};
        vecs[4]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 6'd8};
        vecs[5]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100, 6'd10};
        vecs[6]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd0};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 6'd0};
        vecs[8]  = '{4'b1010, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1010, 6'd9};
        vecs[9]  = '{4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 6'd9};
        vecs[10] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 6'd0};

        set_std(4'b1111, 4'b0000);
        apply_reset(0);
        en = 1'b1;

        // Single request, one-cycle latency, one-cycle pulse
        set_std(4'b0100, 4'b0000);
        p_preg[2] = 6'd9;
        p_areg[2] = 5'd3;
        p_data[2] = 32'hDEAD_BEEF;
        step("single");
        chk("single preg9", 64'(bus.i_preg_rb1), 64'd9);
        chk("single data",  64'(bus.d_preg_rb1), 64'hDEAD_BEEF);
        chk("single gid2",  64'(gid), 64'd2);
        p_valid = '0;
        step("single idle");
        chk("single drop", 64'(bus.i_preg_rb1), 64'd0);
        chk("single cnt1", 64'(cnt), 64'd1);

        for (int v = 0; v < 11; v++) begin
            set_std(vecs[v].valid, vecs[v].zero);
            en    = vecs[v].en;
            pause = vecs[v].pause;
            flush = vecs[v].flush;
            #1;
            chk($sformatf("tbl%0d ready", v), 64'(bus.req_ready), 64'(vecs[v].exp_ready));
            step($sformatf("tbl%0d", v));
            chk($sformatf("tbl%0d preg", v), 64'(bus.i_preg_rb1), 64'(vecs[v].exp_preg));
        end
        en = 1'b1; pause = 1'b0; flush = 1'b0;
        chk("tbl cnt8", 64'(cnt), 64'd8);
        p_valid = '0;
        step("err hold");
        chk("err sticky", 64'(err), 64'd1);

        // Strict rotation from pointer 0
        set_std(4'b1111, 4'b0000);
        apply_reset(0);
        set_std(4'b1111, 4'b0000);
        for (int c = 0; c < 8; c++) begin
            step("rot");
            chk($sformatf("rot gid c%0d", c), 64'(gid), 64'(c % N));
        end
        chk("rot cnt8", 64'(cnt), 64'd8);

        // Pause holds a visible broadcast
        set_std(4'b0010, 4'b0000);
        p_preg[1] = 6'd5;
        step("pause pre");
        set_std(4'b1001, 4'b0000);
        pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step("pause");
            chk("pause hold5", 64'(bus.i_preg_rb1), 64'd5);
        end
        pause = 1'b0;
        step("pause rel");
        chk("pause next gid3", 64'(gid), 64'd3);

        // Flush discards the in-flight broadcast and blocks a waiting pipe
        set_std(4'b0110, 4'b0000);
        p_preg[1] = 6'd7;
        step("flush pre");
        p_valid = 4'b0100;
        flush   = 1'b1;
        #1;
        chk("flush ready2", 64'(bus.req_ready[2]), 64'd0);
        chk("flush vis7",   64'(bus.i_preg_rb1), 64'd7);
        step("flush");
        chk("flush zero", 64'(bus.i_preg_rb1), 64'd0);
        flush = 1'b0;
        step("flush rel");
        chk("flush gid2", 64'(gid), 64'd2);

        // Counter saturation, then asynchronous reset mid-broadcast
        set_std(4'b1111, 4'b0000);
        apply_reset(0);
        set_std(4'b1111, 4'b0000);
        for (int c = 0; c < 20; c++) step("sat");
        chk("sat cnt15", 64'(cnt), 64'(CMAX));
        chk("sat live",  64'(bus.i_preg_rb1 != '0), 64'd1);
        apply_reset(1);
        set_std(4'b1111, 4'b0000);
        step("post rst");
        chk("post rst gid0", 64'(gid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
